// File: rtl/riscv_apu_arbiter.sv
// riscv_apu_arbiter
//   Shares one APU port (FPU / shared unit) between NB_REQ per-core APU
//   dispatchers. Requests are arbitrated round-robin. The owner of each
//   operation in flight is kept in an in-order FIFO, so every response
//   valid is routed back to the requester that issued the operation.
//
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i          per-requester request
//   gnt_o          per-requester grant (one-hot or zero)
//   valid_o        per-requester response valid (one-hot or zero)
//   result_o       response data, broadcast to all requesters
//   sel_o          index of the winning requester (operand mux select)
//   apu_req_o      request to the shared unit
//   apu_gnt_i      grant from the shared unit
//   apu_valid_i    response valid from the shared unit
//   apu_result_i   response data from the shared unit
//   apu_ready_o    always 1
//   busy_o         at least one operation outstanding
//   err_o          sticky protocol error flag
//
// Configuration
//   APU_ARB_ERR_EN  when defined, err_o is a sticky flag that is set by a
//                   response arriving with nothing outstanding, and a
//                   simulation assertion checks that gnt_o is one-hot or
//                   zero. When undefined, err_o is tied to 0.

module riscv_apu_arbiter #(
    parameter int unsigned NB_REQ  = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned WRESULT = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_REQ-1:0]         req_i,
    output logic [NB_REQ-1:0]         gnt_o,
    output logic [NB_REQ-1:0]         valid_o,
    output logic [WRESULT-1:0]        result_o,
    output logic [$clog2(NB_REQ)-1:0] sel_o,
    output logic                      apu_req_o,
    input  logic                      apu_gnt_i,
    input  logic                      apu_valid_i,
    input  logic [WRESULT-1:0]        apu_result_i,
    output logic                      apu_ready_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned SEL_W = $clog2(NB_REQ);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [SEL_W-1:0] r_rr;
    logic [SEL_W-1:0] r_owner [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_winner;
    logic [SEL_W-1:0] w_rr_next;
    logic             w_full;
    logic             w_issue;
    logic             w_pop;

    // Scan from the round-robin pointer upward; the first set request wins.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = '0;
        w_winner = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            w_idx = SEL_W'((32'(r_rr) + i) % NB_REQ);
            if (!w_found && req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Explicit wrap keeps the pointer legal for non-power-of-two NB_REQ.
    assign w_rr_next = (w_winner == SEL_W'(NB_REQ - 1)) ? '0 : w_winner + 1'b1;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign apu_req_o = (|req_i) & ~w_full;
    assign w_issue   = apu_req_o & apu_gnt_i;
    assign w_pop     = apu_valid_i & (r_count != '0);

    assign sel_o       = w_winner;
    assign result_o    = apu_result_i;
    assign apu_ready_o = 1'b1;
    assign busy_o      = (r_count != '0);

    always_comb begin
        gnt_o = '0;
        if (w_issue) begin
            gnt_o[w_winner] = 1'b1;
        end
    end

    always_comb begin
        valid_o = '0;
        if (w_pop) begin
            valid_o[r_owner[r_rd]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr    <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_issue) begin
                r_wr <= r_wr + 1'b1;
                r_rr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Owner storage carries no reset: entries are only read below r_count.
    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_owner[r_wr] <= w_winner;
        end
    end

`ifdef APU_ARB_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (apu_valid_i && (r_count == '0)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// Testbench for riscv_apu_arbiter (NB_REQ=4, DEPTH=4, WRESULT=32).
// A queue-based model predicts every output each cycle; directed vectors
// additionally pin hand-computed values.

module tb_riscv_apu_arbiter;

    localparam int NB  = 4;
    localparam int DP  = 4;
    localparam int WR  = 32;
`ifdef APU_ARB_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [NB-1:0] req_i;
    logic [NB-1:0] gnt_o;
    logic [NB-1:0] valid_o;
    logic [WR-1:0] result_o;
    logic [1:0]    sel_o;
    logic          apu_req_o;
    logic          apu_gnt_i;
    logic          apu_valid_i;
    logic [WR-1:0] apu_result_i;
    logic          apu_ready_o;
    logic          busy_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    riscv_apu_arbiter #(.NB_REQ(NB), .DEPTH(DP), .WRESULT(WR)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .valid_o      (valid_o),
        .result_o     (result_o),
        .sel_o        (sel_o),
        .apu_req_o    (apu_req_o),
        .apu_gnt_i    (apu_gnt_i),
        .apu_valid_i  (apu_valid_i),
        .apu_result_i (apu_result_i),
        .apu_ready_o  (apu_ready_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   q[$];          // owners of outstanding operations, oldest first
    int   m_rr  = 0;
    logic m_err = 1'b0;

    function automatic int m_winner();
        for (int k = 0; k < NB; k++) begin
            if (req_i[(m_rr + k) % NB]) return (m_rr + k) % NB;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                q.delete();
                m_rr  = 0;
                m_err = 1'b0;
            end else begin
                int  w;
                bit  full;
                w    = m_winner();
                full = (q.size() == DP);
                if (apu_valid_i) begin
                    if (q.size() != 0) void'(q.pop_front());
                    else if (ERR_EN) m_err = 1'b1;
                end
                if (w >= 0 && !full && apu_gnt_i) begin
                    q.push_back(w);
                    m_rr = (w + 1) % NB;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            int            w;
            bit            full;
            logic          e_req;
            logic [NB-1:0] e_gnt;
            logic [NB-1:0] e_vld;
            @(negedge clk);
            w     = m_winner();
            full  = (q.size() == DP);
            e_req = (w >= 0) && !full;
            e_gnt = '0;
            if (e_req && apu_gnt_i) e_gnt[w] = 1'b1;
            e_vld = '0;
            if (apu_valid_i && q.size() != 0) e_vld[q[0]] = 1'b1;
            chk("m_apu_req", apu_req_o, e_req);
            chk("m_gnt", gnt_o, e_gnt);
            chk("m_sel", sel_o, (w >= 0) ? w : 0);
            chk("m_valid", valid_o, e_vld);
            chk("m_result", result_o, apu_result_i);
            chk("m_busy", busy_o, q.size() != 0);
            chk("m_ready", apu_ready_o, 1'b1);
            chk("m_err", err_o, m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic [NB-1:0] r, input logic g, input logic v, input logic [WR-1:0] res);
        @(posedge clk);
        #1;
        req_i        = r;
        apu_gnt_i    = g;
        apu_valid_i  = v;
        apu_result_i = res;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0; req_i = '0; apu_gnt_i = 0; apu_valid_i = 0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        #2;
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_i        = '0;
        apu_gnt_i    = 1'b0;
        apu_valid_i  = 1'b0;
        apu_result_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #3;
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_valid", valid_o, 4'b0000);
        chk("rst_apu_req", apu_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sel", sel_o, 2'd0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_ready", apu_ready_o, 1'b1);
        chk("rst_result", result_o, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Single requester, response three cycles after issue
        cyc(4'b0001, 1, 0, 0);
        chk("single_gnt", gnt_o, 4'b0001);
        chk("single_sel", sel_o, 2'd0);
        cyc(4'b0000, 0, 0, 0);
        chk("single_busy", busy_o, 1'b1);
        cyc(4'b0000, 0, 0, 0);
        cyc(4'b0000, 0, 1, 32'h11);
        chk("single_valid", valid_o, 4'b0001);
        chk("single_result", result_o, 32'h11);
        cyc(4'b0000, 0, 0, 0);
        chk("single_idle", busy_o, 1'b0);

        // Round-robin with a response every cycle
        do_reset();
        cyc(4'b1111, 1, 0, 0);   chk("rr_g0", gnt_o, 4'b0001);
        cyc(4'b1111, 1, 1, 1);   chk("rr_g1", gnt_o, 4'b0010); chk("rr_v0", valid_o, 4'b0001);
        cyc(4'b1111, 1, 1, 2);   chk("rr_g2", gnt_o, 4'b0100); chk("rr_v1", valid_o, 4'b0010);
        cyc(4'b1111, 1, 1, 3);   chk("rr_g3", gnt_o, 4'b1000); chk("rr_v2", valid_o, 4'b0100);
        cyc(4'b1111, 1, 1, 4);   chk("rr_g4", gnt_o, 4'b0001); chk("rr_v3", valid_o, 4'b1000);
        cyc(4'b0000, 0, 1, 5);   chk("rr_v4", valid_o, 4'b0001);

        // Back-pressure from the shared unit (rr=1)
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0100, 0, 0, 0);
            chk("bp_req", apu_req_o, 1'b1);
            chk("bp_gnt", gnt_o, 4'b0000);
            chk("bp_sel", sel_o, 2'd2);
        end
        cyc(4'b0100, 1, 0, 0);   chk("bp_gnt_final", gnt_o, 4'b0100);
        cyc(4'b1111, 0, 0, 0);   chk("bp_rr_after", sel_o, 2'd3);
        cyc(4'b0000, 0, 1, 7);   chk("bp_valid", valid_o, 4'b0100);

        // Full FIFO (rr=3)
        cyc(4'b1111, 1, 0, 0);   chk("full_g0", gnt_o, 4'b1000);
        cyc(4'b1111, 1, 0, 0);   chk("full_g1", gnt_o, 4'b0001);
        cyc(4'b1111, 1, 0, 0);   chk("full_g2", gnt_o, 4'b0010);
        cyc(4'b1111, 1, 0, 0);   chk("full_g3", gnt_o, 4'b0100);
        cyc(4'b1111, 1, 0, 0);   chk("full_blk", apu_req_o, 1'b0); chk("full_blk_gnt", gnt_o, 4'b0000);
        cyc(4'b1111, 1, 1, 8);   chk("full_pop_req", apu_req_o, 1'b0); chk("full_pop_v", valid_o, 4'b1000);
        cyc(4'b1111, 1, 0, 0);   chk("full_reopen", apu_req_o, 1'b1); chk("full_reopen_g", gnt_o, 4'b1000);
        cyc(4'b0000, 0, 1, 9);   chk("full_d0", valid_o, 4'b0001);
        cyc(4'b0000, 0, 1, 10);  chk("full_d1", valid_o, 4'b0010);
        cyc(4'b1111, 1, 1, 11);  chk("pp_gnt", gnt_o, 4'b0001); chk("pp_valid", valid_o, 4'b0100);
        cyc(4'b1111, 1, 0, 0);   chk("pp_g3", gnt_o, 4'b0010);
        cyc(4'b1111, 1, 0, 0);   chk("pp_g4", gnt_o, 4'b0100);
        cyc(4'b1111, 1, 0, 0);   chk("pp_full", apu_req_o, 1'b0);
        cyc(4'b0000, 0, 1, 12);  chk("pp_d0", valid_o, 4'b1000);
        cyc(4'b0000, 0, 1, 13);  chk("pp_d1", valid_o, 4'b0001);
        cyc(4'b0000, 0, 1, 14);  chk("pp_d2", valid_o, 4'b0010);
        cyc(4'b0000, 0, 1, 15);  chk("pp_d3", valid_o, 4'b0100);
        cyc(4'b0000, 0, 0, 0);   chk("pp_idle", busy_o, 1'b0);

        // Ordered routing r2, r0, r3 (rr=3)
        cyc(4'b0100, 1, 0, 0);   chk("ord_g2", gnt_o, 4'b0100);
        cyc(4'b0001, 1, 0, 0);   chk("ord_g0", gnt_o, 4'b0001);
        cyc(4'b1000, 1, 0, 0);   chk("ord_g3", gnt_o, 4'b1000);
        cyc(4'b0000, 0, 1, 32'hAAAA_0001);
        chk("ord_v2", valid_o, 4'b0100); chk("ord_r2", result_o, 32'hAAAA_0001);
        cyc(4'b0000, 0, 1, 32'hBBBB_0002);
        chk("ord_v0", valid_o, 4'b0001); chk("ord_r0", result_o, 32'hBBBB_0002);
        cyc(4'b0000, 0, 1, 32'hCCCC_0003);
        chk("ord_v3", valid_o, 4'b1000); chk("ord_r3", result_o, 32'hCCCC_0003);

        // Spurious response, then reset with three outstanding (rr=0)
        cyc(4'b0000, 0, 1, 32'h5A);
        chk("spur_valid", valid_o, 4'b0000);
        cyc(4'b0000, 0, 0, 0);
        chk("spur_err", err_o, ERR_EN);
        chk("spur_busy", busy_o, 1'b0);
        cyc(4'b1111, 1, 0, 0);   chk("mid_g0", gnt_o, 4'b0001);
        cyc(4'b1111, 1, 0, 0);   chk("mid_g1", gnt_o, 4'b0010);
        cyc(4'b1111, 1, 0, 0);   chk("mid_g2", gnt_o, 4'b0100);
        cyc(4'b0000, 0, 0, 0);   chk("mid_busy", busy_o, 1'b1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #2;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_err", err_o, 1'b0);
        chk("mid_rst_req", apu_req_o, 1'b0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cyc(4'b0000, 0, 1, 32'h77);
        chk("post_rst_valid", valid_o, 4'b0000);
        cyc(4'b0000, 0, 0, 0);
        chk("post_rst_err", err_o, ERR_EN);
        cyc(4'b0000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
